// File: rtl/agu_pkg.sv
// Shared types and default sizing for the N-D address generation unit.
// Contents: FSM state encoding, default port widths, done-delay counter width helper.
package agu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned KERN_DIM_WIDTH_DEF  = 3;
  localparam int unsigned COL_WIDTH_DEF       = 8;
  localparam int unsigned ROW_WIDTH_DEF       = 8;
  localparam int unsigned KERN_CNT_WIDTH_DEF  = 3;
  localparam int unsigned IMG_ADDR_WIDTH_DEF  = 16;
  localparam int unsigned KERN_ADDR_WIDTH_DEF = 12;
  localparam int unsigned RSLT_ADDR_WIDTH_DEF = 16;
  localparam int unsigned DONE_DLY_DEF        = 4;

  // Drain counter runs 0..dly-1, so it needs clog2(dly) bits (at least one).
  function automatic int unsigned dly_cnt_w(input int unsigned dly);
    return (dly < 2) ? 1 : $clog2(dly);
  endfunction

endpackage

// File: rtl/agu_wrap_cnt.sv
// Wrapping up-counter used for every loop index and the result address.
// Ports: clk, rst_n (async active-low), i_clr (sync clear, priority),
//        i_en (count), i_last (wrap value), o_cnt (count), o_wrap_c (cnt==last & en).
module agu_wrap_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap_c
);

  logic [W-1:0] r_cnt;

  assign o_wrap_c = i_en && (r_cnt == i_last);
  assign o_cnt    = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cnt <= '0;
    else if (i_clr)    r_cnt <= '0;
    else if (i_en)     r_cnt <= o_wrap_c ? '0 : r_cnt + W'(1);
  end

endmodule

// File: rtl/agu_nd.sv
// Multi-dimensional AGU: walks kernel k / out row r / out col c / kernel row i /
// kernel col j and emits one image and one kernel address per beat, plus a
// result address counter and window-boundary flags.
// Ports: clk, reset (async active-low), start (edge launches a run), stall,
//        en_result_addr, config inputs (shadowed on start), img_addr, kern_addr,
//        result_addr, addr_valid, win_first, win_last, busy, done.
// Optional: AGU_ND_POOL2_EN adds pool_en (result_addr advances every 2nd pulse).
module agu_nd
  import agu_pkg::*;
#(
  parameter int unsigned KERN_DIM_WIDTH  = KERN_DIM_WIDTH_DEF,
  parameter int unsigned COL_WIDTH       = COL_WIDTH_DEF,
  parameter int unsigned ROW_WIDTH       = ROW_WIDTH_DEF,
  parameter int unsigned KERN_CNT_WIDTH  = KERN_CNT_WIDTH_DEF,
  parameter int unsigned IMG_ADDR_WIDTH  = IMG_ADDR_WIDTH_DEF,
  parameter int unsigned KERN_ADDR_WIDTH = KERN_ADDR_WIDTH_DEF,
  parameter int unsigned RSLT_ADDR_WIDTH = RSLT_ADDR_WIDTH_DEF,
  parameter int unsigned DONE_DLY        = DONE_DLY_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stall,
  input  logic                       en_result_addr,
`ifdef AGU_ND_POOL2_EN
  input  logic                       pool_en,
`endif
  input  logic [KERN_DIM_WIDTH-1:0]  kern_rows,
  input  logic [KERN_DIM_WIDTH-1:0]  kern_cols,
  input  logic [COL_WIDTH-1:0]       cols,
  input  logic [ROW_WIDTH-1:0]       out_rows,
  input  logic [COL_WIDTH-1:0]       out_cols,
  input  logic [KERN_CNT_WIDTH-1:0]  kerns,
  input  logic [KERN_DIM_WIDTH-1:0]  stride,
  input  logic [RSLT_ADDR_WIDTH-1:0] result_last,
  output logic [IMG_ADDR_WIDTH-1:0]  img_addr,
  output logic [KERN_ADDR_WIDTH-1:0] kern_addr,
  output logic [RSLT_ADDR_WIDTH-1:0] result_addr,
  output logic                       addr_valid,
  output logic                       win_first,
  output logic                       win_last,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned DLY_W = dly_cnt_w(DONE_DLY);

  state_t                     r_state, w_state_nx;
  logic                       r_start_d, r_busy, r_done;
  logic [DLY_W-1:0]           r_dly_cnt;
  logic                       w_accept, w_step;

  logic [KERN_DIM_WIDTH-1:0]  r_sh_kern_rows, r_sh_kern_cols, r_sh_stride;
  logic [COL_WIDTH-1:0]       r_sh_cols, r_sh_out_cols;
  logic [ROW_WIDTH-1:0]       r_sh_out_rows;
  logic [KERN_CNT_WIDTH-1:0]  r_sh_kerns;
  logic [RSLT_ADDR_WIDTH-1:0] r_sh_result_last;

  logic [IMG_ADDR_WIDTH-1:0]  r_row_base, r_win_base, r_line_base, r_img_addr;
  logic [KERN_ADDR_WIDTH-1:0] r_kern_base, r_kern_addr;
  logic                       r_addr_valid, r_win_first, r_win_last;

  logic [KERN_DIM_WIDTH-1:0]  w_j_cnt, w_i_cnt, w_j_nx, w_i_nx;
  logic [COL_WIDTH-1:0]       w_c_cnt;
  logic [ROW_WIDTH-1:0]       w_r_cnt;
  logic [KERN_CNT_WIDTH-1:0]  w_k_cnt;
  logic                       w_j_wrap, w_i_wrap, w_c_wrap, w_r_wrap, w_k_wrap;
  logic [IMG_ADDR_WIDTH-1:0]  w_img_w, w_row_step, w_row_nx, w_win_nx, w_line_nx;
  logic                       w_res_en, w_res_wrap;
  logic                       w_unused;

  // Start is a level; only a rising edge seen in IDLE or DONE launches a run.
  assign w_accept = start && !r_start_d && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_step   = (r_state == ST_RUN) && !stall;

  // Loop nest, inner to outer; each level steps when the one below wraps.
  agu_wrap_cnt #(.W(KERN_DIM_WIDTH)) u_cnt_j (.clk(clk), .rst_n(reset), .i_clr(w_accept),
    .i_en(w_step),   .i_last(r_sh_kern_cols), .o_cnt(w_j_cnt), .o_wrap_c(w_j_wrap));
  agu_wrap_cnt #(.W(KERN_DIM_WIDTH)) u_cnt_i (.clk(clk), .rst_n(reset), .i_clr(w_accept),
    .i_en(w_j_wrap), .i_last(r_sh_kern_rows), .o_cnt(w_i_cnt), .o_wrap_c(w_i_wrap));
  agu_wrap_cnt #(.W(COL_WIDTH))      u_cnt_c (.clk(clk), .rst_n(reset), .i_clr(w_accept),
    .i_en(w_i_wrap), .i_last(r_sh_out_cols),  .o_cnt(w_c_cnt), .o_wrap_c(w_c_wrap));
  agu_wrap_cnt #(.W(ROW_WIDTH))      u_cnt_r (.clk(clk), .rst_n(reset), .i_clr(w_accept),
    .i_en(w_c_wrap), .i_last(r_sh_out_rows),  .o_cnt(w_r_cnt), .o_wrap_c(w_r_wrap));
  agu_wrap_cnt #(.W(KERN_CNT_WIDTH)) u_cnt_k (.clk(clk), .rst_n(reset), .i_clr(w_accept),
    .i_en(w_r_wrap), .i_last(r_sh_kerns),     .o_cnt(w_k_cnt), .o_wrap_c(w_k_wrap));

  // Next-state decode.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_accept) w_state_nx = ST_RUN;
      ST_RUN:           if (w_k_wrap) w_state_nx = ST_DRAIN;
      ST_DRAIN:         if (r_dly_cnt == DLY_W'(DONE_DLY - 1)) w_state_nx = ST_DONE;
      default:          w_state_nx = ST_IDLE;
    endcase
  end

  // State register plus registered busy/done that track it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_start_d <= 1'b0;
      r_dly_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_start_d <= start;
      r_dly_cnt <= (r_state == ST_DRAIN) ? r_dly_cnt + DLY_W'(1) : '0;
      r_busy    <= (w_state_nx == ST_RUN) || (w_state_nx == ST_DRAIN);
      r_done    <= (w_state_nx == ST_DONE);
    end
  end

  // Row step = stride*(cols+1) by shift-add; stride is only KERN_DIM_WIDTH bits.
  assign w_img_w = IMG_ADDR_WIDTH'(r_sh_cols) + IMG_ADDR_WIDTH'(1);
  always_comb begin
    w_row_step = '0;
    for (int b = 0; b < int'(KERN_DIM_WIDTH); b++) begin
      if (r_sh_stride[b]) w_row_step = w_row_step + (w_img_w << b);
    end
  end

  assign w_row_nx  = r_row_base + w_row_step;
  assign w_win_nx  = r_win_base + IMG_ADDR_WIDTH'(r_sh_stride);
  assign w_line_nx = r_line_base + w_img_w;

  // Kernel indices of the beat that follows the current one, for window flags.
  assign w_j_nx = w_j_wrap ? '0 : w_j_cnt + KERN_DIM_WIDTH'(1);
  assign w_i_nx = w_i_wrap ? '0 : (w_j_wrap ? w_i_cnt + KERN_DIM_WIDTH'(1) : w_i_cnt);

  // Config shadow and incremental address registers; the highest wrapping
  // level decides which base is reloaded. Kernel data is contiguous, so the
  // next kernel (and next kernel row) always starts one past the current address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_kern_rows   <= '0;
      r_sh_kern_cols   <= '0;
      r_sh_stride      <= '0;
      r_sh_cols        <= '0;
      r_sh_out_cols    <= '0;
      r_sh_out_rows    <= '0;
      r_sh_kerns       <= '0;
      r_sh_result_last <= '0;
      r_row_base       <= '0;
      r_win_base       <= '0;
      r_line_base      <= '0;
      r_img_addr       <= '0;
      r_kern_base      <= '0;
      r_kern_addr      <= '0;
      r_addr_valid     <= 1'b0;
      r_win_first      <= 1'b0;
      r_win_last       <= 1'b0;
    end else if (w_accept) begin
      r_sh_kern_rows   <= kern_rows;
      r_sh_kern_cols   <= kern_cols;
      r_sh_stride      <= stride;
      r_sh_cols        <= cols;
      r_sh_out_cols    <= out_cols;
      r_sh_out_rows    <= out_rows;
      r_sh_kerns       <= kerns;
      r_sh_result_last <= result_last;
      r_row_base       <= '0;
      r_win_base       <= '0;
      r_line_base      <= '0;
      r_img_addr       <= '0;
      r_kern_base      <= '0;
      r_kern_addr      <= '0;
      r_addr_valid     <= 1'b1;
      r_win_first      <= 1'b1;
      r_win_last       <= (kern_rows == '0) && (kern_cols == '0);
    end else if (w_step) begin
      if (w_k_wrap) begin
        r_addr_valid <= 1'b0;
        r_win_first  <= 1'b0;
        r_win_last   <= 1'b0;
      end else begin
        r_win_first <= (w_j_nx == '0) && (w_i_nx == '0);
        r_win_last  <= (w_j_nx == r_sh_kern_cols) && (w_i_nx == r_sh_kern_rows);
        if (w_r_wrap) begin
          r_row_base  <= '0;
          r_win_base  <= '0;
          r_line_base <= '0;
          r_img_addr  <= '0;
          r_kern_base <= r_kern_addr + KERN_ADDR_WIDTH'(1);
          r_kern_addr <= r_kern_addr + KERN_ADDR_WIDTH'(1);
        end else if (w_c_wrap) begin
          r_row_base  <= w_row_nx;
          r_win_base  <= w_row_nx;
          r_line_base <= w_row_nx;
          r_img_addr  <= w_row_nx;
          r_kern_addr <= r_kern_base;
        end else if (w_i_wrap) begin
          r_win_base  <= w_win_nx;
          r_line_base <= w_win_nx;
          r_img_addr  <= w_win_nx;
          r_kern_addr <= r_kern_base;
        end else if (w_j_wrap) begin
          r_line_base <= w_line_nx;
          r_img_addr  <= w_line_nx;
          r_kern_addr <= r_kern_addr + KERN_ADDR_WIDTH'(1);
        end else begin
          r_img_addr  <= r_img_addr + IMG_ADDR_WIDTH'(1);
          r_kern_addr <= r_kern_addr + KERN_ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Result counter enable; a pulse coinciding with start acceptance is dropped.
`ifdef AGU_ND_POOL2_EN
  logic r_sh_pool_en, r_pool_ph;

  // Phase toggles per pulse; the advancing pulse (and thus any wrap) returns it to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_pool_en <= 1'b0;
      r_pool_ph    <= 1'b0;
    end else if (w_accept) begin
      r_sh_pool_en <= pool_en;
      r_pool_ph    <= 1'b0;
    end else if (en_result_addr && r_sh_pool_en) begin
      r_pool_ph    <= !r_pool_ph;
    end
  end

  assign w_res_en = en_result_addr && !w_accept && (!r_sh_pool_en || r_pool_ph);
`else
  assign w_res_en = en_result_addr && !w_accept;
`endif

  agu_wrap_cnt #(.W(RSLT_ADDR_WIDTH)) u_cnt_res (.clk(clk), .rst_n(reset), .i_clr(w_accept),
    .i_en(w_res_en), .i_last(r_sh_result_last), .o_cnt(result_addr), .o_wrap_c(w_res_wrap));

  assign w_unused = ^{w_c_cnt, w_r_cnt, w_k_cnt, w_res_wrap};

  assign img_addr   = r_img_addr;
  assign kern_addr  = r_kern_addr;
  assign addr_valid = r_addr_valid;
  assign win_first  = r_win_first;
  assign win_last   = r_win_last;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_agu_nd.sv
// Directed testbench for agu_nd: address sequences, stride, multi-kernel,
// stall, mid-run reset, result counter wrap (and pool mode with AGU_ND_POOL2_EN).
module tb_agu_nd;

  localparam int DONE_DLY = 4;

  logic        clk = 1'b0;
  logic        reset, start, stall, en_result_addr;
`ifdef AGU_ND_POOL2_EN
  logic        pool_en;
`endif
  logic [2:0]  kern_rows, kern_cols, stride, kerns;
  logic [7:0]  cols, out_rows, out_cols;
  logic [15:0] result_last;
  logic [15:0] img_addr, result_addr;
  logic [11:0] kern_addr;
  logic        addr_valid, win_first, win_last, busy, done;

  always #5 clk = ~clk;

  agu_nd u_dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .en_result_addr(en_result_addr),
`ifdef AGU_ND_POOL2_EN
    .pool_en(pool_en),
`endif
    .kern_rows(kern_rows), .kern_cols(kern_cols), .cols(cols), .out_rows(out_rows),
    .out_cols(out_cols), .kerns(kerns), .stride(stride), .result_last(result_last),
    .img_addr(img_addr), .kern_addr(kern_addr), .result_addr(result_addr),
    .addr_valid(addr_valid), .win_first(win_first), .win_last(win_last),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] img_q[$];
  logic [11:0] kern_q[$];
  bit          first_q[$], last_q[$];
  logic [15:0] exp_img[$];
  logic [11:0] exp_kern[$];
  bit          exp_first[$], exp_last[$];
  int n_beats, repeat_cycles, repeat_bad, done_cyc, last_cyc, busy_bad, busy_at_done;

  task automatic set_cfg(input int kr, input int kc, input int c, input int orr,
                         input int oc, input int k, input int s);
    kern_rows = 3'(kr); kern_cols = 3'(kc); cols = 8'(c);
    out_rows = 8'(orr); out_cols = 8'(oc); kerns = 3'(k); stride = 3'(s);
  endtask

  // Returns #1 into the cycle after acceptance (first beat visible).
  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Expected beat stream from the closed-form address equations.
  task automatic build_exp();
    int w;
    exp_img.delete(); exp_kern.delete(); exp_first.delete(); exp_last.delete();
    w = int'(cols) + 1;
    for (int k = 0; k <= int'(kerns); k++)
      for (int r = 0; r <= int'(out_rows); r++)
        for (int c = 0; c <= int'(out_cols); c++)
          for (int i = 0; i <= int'(kern_rows); i++)
            for (int j = 0; j <= int'(kern_cols); j++) begin
              exp_img.push_back(16'((r * int'(stride) + i) * w + c * int'(stride) + j));
              exp_kern.push_back(12'(k * (int'(kern_rows) + 1) * (int'(kern_cols) + 1)
                                     + i * (int'(kern_cols) + 1) + j));
              exp_first.push_back(i == 0 && j == 0);
              exp_last.push_back(i == int'(kern_rows) && j == int'(kern_cols));
            end
  endtask

  // Called right after do_start; cycle 1 is the first-beat cycle.
  task automatic run_collect(input int stall_beat, input int stall_len, input int abort_beat);
    int  stall_left;
    bit  stalled, fin;
    stall_left = 0; fin = 1'b0;
    img_q.delete(); kern_q.delete(); first_q.delete(); last_q.delete();
    n_beats = 0; repeat_cycles = 0; repeat_bad = 0; done_cyc = -1; last_cyc = -1;
    busy_bad = 0; busy_at_done = 1;
    for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      stalled = stall;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) stall = 1'b0;
      end
      if (done) begin
        done_cyc = cyc; busy_at_done = busy; fin = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_bad++;
        if (addr_valid) begin
          last_cyc = cyc;
          if (stalled) begin
            repeat_cycles++;
            if (img_addr !== img_q[$] || kern_addr !== kern_q[$]) repeat_bad++;
          end else begin
            img_q.push_back(img_addr); kern_q.push_back(kern_addr);
            first_q.push_back(win_first); last_q.push_back(win_last);
            n_beats++;
            if (n_beats - 1 == stall_beat && stall_len > 0) begin
              stall = 1'b1; stall_left = stall_len;
            end
            if (n_beats == abort_beat) fin = 1'b1;
          end
        end
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL run_timeout: no done within 3000 cycles, beats seen %0d", n_beats);
    end
  endtask

  task automatic check_seq(input string name);
    int bad;
    bad = -1;
    checks++;
    if (img_q.size() != exp_img.size()) begin
      errors++;
      $display("FAIL %s_len: got %0d beats expected %0d", name, img_q.size(), exp_img.size());
    end else begin
      for (int n = 0; n < img_q.size(); n++)
        if (bad < 0 && (img_q[n] !== exp_img[n] || kern_q[n] !== exp_kern[n] ||
                        first_q[n] !== exp_first[n] || last_q[n] !== exp_last[n])) bad = n;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s_seq beat %0d: got img=%0d kern=%0d f=%0d l=%0d expected img=%0d kern=%0d f=%0d l=%0d",
                 name, bad, img_q[bad], kern_q[bad], first_q[bad], last_q[bad],
                 exp_img[bad], exp_kern[bad], exp_first[bad], exp_last[bad]);
      end
    end
  endtask

  task automatic check_done_timing(input string name, input int exp_len);
    checks++;
    if (done_cyc - last_cyc != DONE_DLY + 1) begin
      errors++;
      $display("FAIL %s_done_lat: got %0d expected %0d", name, done_cyc - last_cyc, DONE_DLY + 1);
    end
    checks++;
    if (done_cyc != exp_len) begin
      errors++;
      $display("FAIL %s_run_len: got %0d expected %0d", name, done_cyc, exp_len);
    end
    checks++;
    if (busy_bad != 0 || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: got bad=%0d at_done=%0d expected bad=0 at_done=0", name, busy_bad, busy_at_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({img_addr, kern_addr, result_addr, addr_valid, win_first, win_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got img=%0d kern=%0d res=%0d v=%0d f=%0d l=%0d b=%0d d=%0d expected all 0",
               img_addr, kern_addr, result_addr, addr_valid, win_first, win_last, busy, done);
    end
    reset = 1'b1;
  endtask

  task automatic test_3x3_stride1();
    logic [15:0] win0 [9];
    win0 = '{16'd0, 16'd1, 16'd2, 16'd5, 16'd6, 16'd7, 16'd10, 16'd11, 16'd12};
    set_cfg(2, 2, 4, 2, 2, 0, 1);
    build_exp();
    do_start();
    checks++;
    if (img_addr !== 16'd0 || kern_addr !== 12'd0 || win_first !== 1'b1 || addr_valid !== 1'b1) begin
      errors++;
      $display("FAIL s1_first_beat: got img=%0d kern=%0d f=%0d v=%0d expected 0 0 1 1",
               img_addr, kern_addr, win_first, addr_valid);
    end
    run_collect(-1, 0, -1);
    for (int n = 0; n < 9; n++) begin
      checks++;
      if (n_beats < 9 || img_q[n] !== win0[n]) begin
        errors++;
        $display("FAIL s1_win0[%0d]: got %0d expected %0d", n, (n_beats > n) ? img_q[n] : 16'hffff, win0[n]);
      end
    end
    checks++;
    if (n_beats < 10 || img_q[9] !== 16'd1 || first_q[9] !== 1'b1 || last_q[8] !== 1'b1) begin
      errors++;
      $display("FAIL s1_win1_start: got img=%0d f=%0d prev_l=%0d expected 1 1 1",
               (n_beats > 9) ? img_q[9] : 16'hffff, (n_beats > 9) ? first_q[9] : 1'b0,
               (n_beats > 8) ? last_q[8] : 1'b0);
    end
    check_seq("s1");
    check_done_timing("s1", 81 + DONE_DLY + 1);
    checks++;
    if (addr_valid !== 1'b0 || win_first !== 1'b0 || img_addr !== 16'd24 || kern_addr !== 12'd8) begin
      errors++;
      $display("FAIL s1_hold_after: got v=%0d f=%0d img=%0d kern=%0d expected 0 0 24 8",
               addr_valid, win_first, img_addr, kern_addr);
    end
  endtask

  task automatic test_stride2();
    logic [15:0] starts [4];
    starts = '{16'd0, 16'd2, 16'd10, 16'd12};
    set_cfg(2, 2, 4, 1, 1, 0, 2);
    build_exp();
    do_start();
    run_collect(-1, 0, -1);
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (n_beats <= w * 9 || img_q[w * 9] !== starts[w]) begin
        errors++;
        $display("FAIL s2_win%0d_start: got %0d expected %0d", w,
                 (n_beats > w * 9) ? img_q[w * 9] : 16'hffff, starts[w]);
      end
    end
    check_seq("s2");
    check_done_timing("s2", 36 + DONE_DLY + 1);
  endtask

  task automatic test_multi_kern();
    set_cfg(2, 2, 4, 2, 2, 1, 1);
    build_exp();
    do_start();
    run_collect(-1, 0, -1);
    checks++;
    if (n_beats != 162 || img_q[80] !== 16'd24 || kern_q[80] !== 12'd8 ||
        img_q[81] !== 16'd0 || kern_q[81] !== 12'd9) begin
      errors++;
      $display("FAIL mk_boundary: got beats=%0d img %0d->%0d kern %0d->%0d expected 162 24->0 8->9",
               n_beats, (n_beats > 81) ? img_q[80] : 16'hffff, (n_beats > 81) ? img_q[81] : 16'hffff,
               (n_beats > 81) ? kern_q[80] : 12'hfff, (n_beats > 81) ? kern_q[81] : 12'hfff);
    end
    check_seq("mk");
  endtask

  task automatic test_1x1();
    set_cfg(0, 0, 1, 1, 1, 0, 1);
    build_exp();
    do_start();
    run_collect(-1, 0, -1);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (n_beats != 4 || img_q[n] !== 16'(n) || first_q[n] !== 1'b1 || last_q[n] !== 1'b1) begin
        errors++;
        $display("FAIL k1x1_beat%0d: got beats=%0d img=%0d f=%0d l=%0d expected 4 %0d 1 1", n, n_beats,
                 (n_beats > n) ? img_q[n] : 16'hffff, (n_beats > n) ? first_q[n] : 1'b0,
                 (n_beats > n) ? last_q[n] : 1'b0, n);
      end
    end
    check_done_timing("k1x1", 4 + DONE_DLY + 1);
  endtask

  task automatic test_stall();
    set_cfg(2, 2, 4, 2, 2, 0, 1);
    build_exp();
    do_start();
    run_collect(4, 3, -1);
    checks++;
    if (repeat_cycles != 3 || repeat_bad != 0) begin
      errors++;
      $display("FAIL stall_hold: got repeats=%0d changed=%0d expected 3 0", repeat_cycles, repeat_bad);
    end
    check_seq("stall");
    check_done_timing("stall", 81 + DONE_DLY + 1 + 3);
  endtask

  task automatic test_reset_restart();
    set_cfg(2, 2, 4, 2, 2, 0, 1);
    build_exp();
    do_start();
    run_collect(-1, 0, 20);
    reset = 1'b0;
    #1;
    checks++;
    if ({img_addr, kern_addr, result_addr, addr_valid, win_first, win_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got img=%0d kern=%0d v=%0d b=%0d d=%0d expected all 0",
               img_addr, kern_addr, addr_valid, busy, done);
    end
    repeat (DONE_DLY + 3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d expected 0", done);
    end
    reset = 1'b1;
    do_start();
    run_collect(-1, 0, -1);
    check_seq("restart");
    check_done_timing("restart", 81 + DONE_DLY + 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: got done=%0d expected 1", done);
    end
  endtask

  task automatic test_result_wrap();
    logic [15:0] exp_res [5];
    exp_res = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
    set_cfg(0, 0, 1, 1, 1, 0, 1);
    result_last = 16'd3;
    do_start();
    en_result_addr = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      checks++;
      if (result_addr !== exp_res[n]) begin
        errors++;
        $display("FAIL res_wrap[%0d]: got %0d expected %0d", n, result_addr, exp_res[n]);
      end
    end
    en_result_addr = 1'b0;
    wait_done();
    // Restart from DONE with a coincident pulse: counter clears, pulse dropped.
    start = 1'b1; en_result_addr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; en_result_addr = 1'b0;
    checks++;
    if (result_addr !== 16'd0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL res_clear_on_start: got res=%0d done=%0d busy=%0d expected 0 0 1",
               result_addr, done, busy);
    end
    wait_done();
  endtask

`ifdef AGU_ND_POOL2_EN
  task automatic test_pool();
    logic [15:0] exp_res [8];
    exp_res = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd0};
    pool_en = 1'b1;
    result_last = 16'd3;
    do_start();
    en_result_addr = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      checks++;
      if (result_addr !== exp_res[n]) begin
        errors++;
        $display("FAIL pool[%0d]: got %0d expected %0d", n, result_addr, exp_res[n]);
      end
    end
    en_result_addr = 1'b0;
    pool_en = 1'b0;
    wait_done();
  endtask
`endif

  initial begin
    reset = 1'b0; start = 1'b0; stall = 1'b0; en_result_addr = 1'b0;
`ifdef AGU_ND_POOL2_EN
    pool_en = 1'b0;
`endif
    result_last = 16'hffff;
    set_cfg(0, 0, 0, 0, 0, 0, 1);
    test_reset();
    test_3x3_stride1();
    test_stride2();
    test_multi_kern();
    test_1x1();
    test_stall();
    test_reset_restart();
    test_result_wrap();
`ifdef AGU_ND_POOL2_EN
    test_pool();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
